unidade_controle_jogo: RTL and testbench

//  Control unit for the LED-matrix puzzle: sequences the level counter (contaN/zeraN) and the

---
 rtl/jogo_pkg.sv | 46 ++++
 rtl/unidade_controle_jogo_contador_tempo.sv | 29 ++
 rtl/unidade_controle_jogo.sv | 85 ++++++++
 tb/tb_unidade_controle_jogo.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the LED-matrix puzzle control unit: state codes,
// output bundle and the Moore output decode.
package jogo_pkg;

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    PREPARA = 3'd1,
    CARREGA = 3'd2,
    JOGANDO = 3'd3,
    PROXIMO = 3'd4,
    PAUSA   = 3'd5,
    VENCEU  = 3'd6,
    PERDEU  = 3'd7
  } estado_t;

  localparam logic [2:0] ULTIMO_NIVEL = 3'd4;
  localparam int         DB_ESTADO_W  = 4;

  typedef struct packed {
    logic zera_n;
    logic conta_n;
    logic zera_m;
    logic pronto;
    logic ganhou;
    logic perdeu;
  } saidas_t;

  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      PREPARA: begin s.zera_n = 1'b1; s.zera_m = 1'b1; end
      CARREGA: s.zera_m = 1'b1;
      PROXIMO: s.conta_n = 1'b1;
      VENCEU:  begin s.pronto = 1'b1; s.ganhou = 1'b1; end
      PERDEU:  begin s.pronto = 1'b1; s.perdeu = 1'b1; end
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/unidade_controle_jogo_contador_tempo.sv
// Cycle timer with synchronous clear and enable; flags when the count equals
// a runtime limit so one counter serves both level timeout and pause length.
module contador_tempo #(
  parameter int W = 26
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpa,
  input  logic         habilita,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (limpa)         valor_d = '0;
    else if (habilita) valor_d = valor_q + W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valor_q <= '0;
    else        valor_q <= valor_d;
  end

  assign fim = (valor_q == limite);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Game control FSM: starts a game, reloads the matrix each level, times each
// level and the inter-level pause, and reports win/loss.
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int PAUSA_CYCLES   = 25_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   nivel_concluido,
  input  logic                   nivelIgualUltimoNivel,
  output logic                   zeraN,
  output logic                   contaN,
  output logic                   zeraM,
  output logic                   pronto,
  output logic                   ganhou,
  output logic                   perdeu,
  output logic [DB_ESTADO_W-1:0] db_estado
);

  localparam int TW = $clog2(max_int(TIMEOUT_CYCLES, PAUSA_CYCLES));
  localparam logic [TW-1:0] LIM_JOGO  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LIM_PAUSA = TW'(PAUSA_CYCLES - 1);

  estado_t       state_q, state_d;
  saidas_t       saidas_q, saidas_d;
  logic          timer_limpa, timer_habilita, timer_fim;
  logic [TW-1:0] timer_limite;

  // Timer is cleared in the single cycle before each timed state.
  assign timer_limpa    = (state_q == CARREGA) || (state_q == PROXIMO);
  assign timer_habilita = (state_q == JOGANDO) || (state_q == PAUSA);
  assign timer_limite   = (state_q == PAUSA) ? LIM_PAUSA : LIM_JOGO;

  contador_tempo #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .limpa    (timer_limpa),
    .habilita (timer_habilita),
    .limite   (timer_limite),
    .fim      (timer_fim)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: state_d = CARREGA;
      CARREGA: state_d = JOGANDO;
      JOGANDO: begin
        // Completion takes priority over a coincident timeout.
        if (nivel_concluido && nivelIgualUltimoNivel) state_d = VENCEU;
        else if (nivel_concluido)                     state_d = PROXIMO;
        else if (timer_fim)                           state_d = PERDEU;
      end
      PROXIMO: state_d = PAUSA;
      PAUSA:   if (timer_fim) state_d = CARREGA;
      VENCEU:  if (iniciar) state_d = PREPARA;
      PERDEU:  if (iniciar) state_d = PREPARA;
      default: state_d = INICIAL;
    endcase
    saidas_d = decodifica(state_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= INICIAL;
      saidas_q <= '0;
    end else begin
      state_q  <= state_d;
      saidas_q <= saidas_d;
    end
  end

  assign zeraN     = saidas_q.zera_n;
  assign contaN    = saidas_q.conta_n;
  assign zeraM     = saidas_q.zera_m;
  assign pronto    = saidas_q.pronto;
  assign ganhou    = saidas_q.ganhou;
  assign perdeu    = saidas_q.perdeu;
  assign db_estado = DB_ESTADO_W'(state_q);

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for the game control unit: a planned timeline of per-cycle inputs and
// expected outputs, built from the game rules, is replayed and compared.
module tb_unidade_controle_jogo;

  localparam int T = 20;
  localparam int P = 5;

  localparam logic [3:0] S_INI = 4'd0, S_PRE = 4'd1, S_CAR = 4'd2, S_JOG = 4'd3,
                         S_PRX = 4'd4, S_PAU = 4'd5, S_VEN = 4'd6, S_PER = 4'd7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, nivel_concluido = 1'b0, nivel_igual = 1'b0;
  logic zeraN, contaN, zeraM, pronto, ganhou, perdeu;
  logic [3:0] db_estado;

  logic [2:0] in_q[$];
  logic [9:0] exp_q[$];
  string      tag_q[$];

  int errors = 0;
  int checks = 0;
  int contan_seen = 0;
  int contan_plan = 0;

  always #5 clock = ~clock;

  unidade_controle_jogo #(.TIMEOUT_CYCLES(T), .PAUSA_CYCLES(P)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .iniciar               (iniciar),
    .nivel_concluido       (nivel_concluido),
    .nivelIgualUltimoNivel (nivel_igual),
    .zeraN                 (zeraN),
    .contaN                (contaN),
    .zeraM                 (zeraM),
    .pronto                (pronto),
    .ganhou                (ganhou),
    .perdeu                (perdeu),
    .db_estado             (db_estado)
  );

  // Expected observation: {code, zeraN, contaN, zeraM, pronto, ganhou, perdeu}.
  function automatic logic [9:0] esperado(input logic [3:0] c);
    logic [5:0] o;
    case (c)
      S_PRE:   o = 6'b101000;
      S_CAR:   o = 6'b001000;
      S_PRX:   o = 6'b010000;
      S_VEN:   o = 6'b000110;
      S_PER:   o = 6'b000101;
      default: o = 6'b000000;
    endcase
    return {c, o};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic plan(input logic [2:0] inp, input logic [3:0] c, input string t);
    in_q.push_back(inp);
    exp_q.push_back(esperado(c));
    tag_q.push_back(t);
  endtask

  task automatic plan_hold(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) plan({1'b0, rb(), rb()}, c, "hold");
  endtask

  // From INICIAL/VENCEU/PERDEU: iniciar, then PREPARA, CARREGA, first JOGANDO cycle.
  task automatic plan_start();
    plan({1'b1, rb(), rb()}, S_PRE, "start_prepara");
    plan({rb(), rb(), rb()}, S_CAR, "start_carrega");
    plan({rb(), rb(), rb()}, S_JOG, "start_jogando");
  endtask

  // Level solved during its d-th JOGANDO cycle (0-based).
  task automatic plan_level(input int d, input logic last);
    for (int i = 0; i < d; i++) plan({rb(), 1'b0, rb()}, S_JOG, "jogando");
    if (last) begin
      plan({rb(), 1'b1, 1'b1}, S_VEN, "venceu");
    end else begin
      plan({rb(), 1'b1, 1'b0}, S_PRX, "proximo");
      contan_plan++;
      for (int i = 0; i < P; i++) plan({rb(), rb(), rb()}, S_PAU, "pausa");
      plan({rb(), rb(), rb()}, S_CAR, "recarrega");
      plan({rb(), rb(), rb()}, S_JOG, "jogando_novo");
    end
  endtask

  task automatic plan_timeout();
    for (int i = 0; i < T - 1; i++) plan({rb(), 1'b0, rb()}, S_JOG, "jogando_t");
    plan({rb(), 1'b0, rb()}, S_PER, "perdeu");
  endtask

  task automatic run_plan();
    logic [9:0] obs, exp;
    string t;
    while (in_q.size() > 0) begin
      {iniciar, nivel_concluido, nivel_igual} = in_q.pop_front();
      @(posedge clock);
      #1;
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {db_estado, zeraN, contaN, zeraM, pronto, ganhou, perdeu};
      if (contaN === 1'b1) contan_seen++;
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, exp);
      end
    end
  endtask

  task automatic check_zero(input string t);
    logic [9:0] obs;
    obs = {db_estado, zeraN, contaN, zeraM, pronto, ganhou, perdeu};
    checks++;
    assert (obs === 10'd0) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, 10'd0);
    end
  endtask

  initial begin
    int   r, d;
    logic last, won;

    // Reset state
    #1 reset = 1'b0;
    #1 check_zero("reset_async_init");
    @(posedge clock); #1;
    check_zero("reset_held");
    reset = 1'b1;
    plan_hold(S_INI, 3);
    run_plan();

    // Start timing, then a level solved on its first cycle and one at random
    plan_start();
    plan_level(0, 1'b0);
    plan_level($urandom_range(0, T - 1), 1'b0);
    run_plan();

    // Full win: four intermediate completions, last one on the fifth
    plan_hold(S_JOG, 0);
    contan_seen = 0;
    contan_plan = 0;
    in_q.delete(); exp_q.delete(); tag_q.delete();
    {iniciar, nivel_concluido, nivel_igual} = 3'b000;
    reset = 1'b0;
    #1 check_zero("reset_before_win");
    @(posedge clock); #1;
    reset = 1'b1;
    plan_start();
    for (int i = 0; i < 4; i++) plan_level($urandom_range(0, T - 1), 1'b0);
    plan_level($urandom_range(0, T - 1), 1'b1);
    plan_hold(S_VEN, 3);
    run_plan();
    checks++;
    assert (contan_seen === contan_plan && contan_plan == 4) else begin
      errors++;
      $error("FAIL contan_count observed=%0d expected=%0d", contan_seen, 4);
    end

    // Restart from VENCEU, complete exactly on the timeout cycle, then time out
    plan_start();
    plan_level(T - 1, 1'b0);
    plan_timeout();
    plan_hold(S_PER, 3);
    // Restart from PERDEU and play a few cycles
    plan_start();
    for (int i = 0; i < 6; i++) plan({rb(), 1'b0, rb()}, S_JOG, "jogando_pre_reset");
    run_plan();

    // Asynchronous reset mid-JOGANDO, checked before the next edge
    #3 reset = 1'b0;
    #1 check_zero("reset_mid_game");
    @(posedge clock); #1;
    check_zero("reset_mid_game_held");
    reset = 1'b1;
    plan_hold(S_INI, 2);
    run_plan();

    // Random games
    for (int g = 0; g < 5; g++) begin
      won = 1'b0;
      plan_start();
      for (int lv = 0; lv < 6; lv++) begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          plan_timeout();
          break;
        end
        d    = $urandom_range(0, T - 1);
        last = (lv == 5) || ($urandom_range(0, 2) == 0);
        plan_level(d, last);
        if (last) begin
          won = 1'b1;
          break;
        end
      end
      plan_hold(won ? S_VEN : S_PER, 2);
      run_plan();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
